// File: rtl/wf_delay_line.sv
// Sample delay stage: a circular buffer that emits each accepted sample together
// with the sample accepted dly_q samples earlier, behind one registered output stage.
module wf_delay_line #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int DLY_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DLY_W-1:0]  cfg_delay,
    input  logic              cfg_load,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [DATA_W-1:0] m_delayed,
    output logic              m_valid,
    output logic              delay_valid,
    input  logic              m_ready
);

    typedef enum logic {FILL, RUN} state_t;

    localparam logic [DLY_W-1:0] ONE = 1;

    logic [DATA_W-1:0] buf_mem [DEPTH];
    logic [DLY_W-1:0]  wr_ptr;
    logic [DLY_W-1:0]  fill;
    logic [DLY_W-1:0]  dly_q;
    state_t            state;

    logic              accept;
    logic [DLY_W-1:0]  eff_dly;
    logic [DLY_W-1:0]  eff_fill;
    state_t            eff_state;
    logic [DLY_W-1:0]  rd_ptr;
    logic [DLY_W-1:0]  fill_inc;
    logic [DLY_W-1:0]  fill_next;
    state_t            state_next;
    logic              tap_valid;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    // A load takes effect for an accept in the same cycle, so resolve the
    // delay/fill/state that this cycle's sample should see first.
    // The cfg_delay port is only DLY_W bits wide, so it can never exceed DEPTH-1.
    always_comb begin
        eff_dly    = cfg_load ? cfg_delay : dly_q;
        eff_fill   = cfg_load ? '0 : fill;
        eff_state  = cfg_load ? FILL : state;
        rd_ptr     = wr_ptr - eff_dly;
        fill_inc   = eff_fill + ONE;
        fill_next  = eff_fill;
        state_next = eff_state;
        tap_valid  = 1'b1;
        case (eff_state)
            FILL: begin
                tap_valid = (eff_fill >= eff_dly);
                if (accept)
                    fill_next = fill_inc;
                if (eff_dly == '0)
                    state_next = RUN;
                else if (accept && (fill_inc >= eff_dly))
                    state_next = RUN;
            end
            RUN: begin
                tap_valid = 1'b1;
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept)
            buf_mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            m_valid     <= 1'b0;
            delay_valid <= 1'b0;
            m_data      <= '0;
            m_delayed   <= '0;
            wr_ptr      <= '0;
            fill        <= '0;
            dly_q       <= '0;
            state       <= FILL;
        end else begin
            if (cfg_load)
                dly_q <= cfg_delay;
            fill  <= fill_next;
            state <= state_next;
            if (accept) begin
                wr_ptr      <= wr_ptr + ONE;
                m_data      <= s_data;
                m_delayed   <= (eff_dly == '0) ? s_data : buf_mem[rd_ptr];
                delay_valid <= tap_valid;
                m_valid     <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wf_delay_line.sv
// Directed bench for wf_delay_line: a DEPTH=64 instance for most sequences and a
// DEPTH=8 instance, fed identically, for the pointer-wrap sequence.
module tb_wf_delay_line;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  cfg_delay;
    logic [2:0]  cfg_delay8;
    logic        cfg_load;
    logic [15:0] s_data;
    logic        s_valid;
    logic        m_ready;

    logic        s_ready, m_valid, delay_valid;
    logic [15:0] m_data, m_delayed;
    logic        s_ready8, m_valid8, delay_valid8;
    logic [15:0] m_data8, m_delayed8;

    int pass_cnt = 0;
    int total_cnt = 0;

    assign cfg_delay8 = cfg_delay[2:0];

    always #5 clk = ~clk;

    wf_delay_line #(.DATA_W(16), .DEPTH(64)) u64 (
        .clk(clk), .reset(reset), .cfg_delay(cfg_delay), .cfg_load(cfg_load),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_delayed(m_delayed), .m_valid(m_valid),
        .delay_valid(delay_valid), .m_ready(m_ready)
    );

    wf_delay_line #(.DATA_W(16), .DEPTH(8)) u8 (
        .clk(clk), .reset(reset), .cfg_delay(cfg_delay8), .cfg_load(cfg_load),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready8),
        .m_data(m_data8), .m_delayed(m_delayed8), .m_valid(m_valid8),
        .delay_valid(delay_valid8), .m_ready(m_ready)
    );

    typedef struct {
        logic        ld;
        logic [5:0]  dly;
        logic        sv;
        logic [15:0] sd;
        logic        mv;
        logic [15:0] md;
        logic        dv;
        logic        chk_tap;
        logic [15:0] mdl;
    } vec_t;

    vec_t tbl[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs are driven 1 time unit after a rising edge; the call returns
    // 1 unit after the next rising edge so outputs are settled for sampling.
    task automatic applyStimulus(input logic ld, input logic [5:0] dly, input logic sv,
                                 input logic [15:0] sd, input logic mr);
        cfg_load  = ld;
        cfg_delay = dly;
        s_valid   = sv;
        s_data    = sd;
        m_ready   = mr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; cfg_load = 1'b0; cfg_delay = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_m_valid", m_valid, 0);
        checkOutput("reset_delay_valid", delay_valid, 0);
        checkOutput("reset_m_data", m_data, 0);
        checkOutput("reset_m_delayed", m_delayed, 0);
        checkOutput("reset_s_ready", s_ready, 1);
        reset = 1'b1;

        // delay 3 then delay 0 (bypass) sequences
        tbl.push_back('{1'b1, 6'd3, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{1'b0, 6'd0, 1'b1, 16'd1, 1'b1, 16'd1, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{1'b0, 6'd0, 1'b1, 16'd2, 1'b1, 16'd2, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{1'b0, 6'd0, 1'b1, 16'd3, 1'b1, 16'd3, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{1'b0, 6'd0, 1'b1, 16'd4, 1'b1, 16'd4, 1'b1, 1'b1, 16'd1});
        tbl.push_back('{1'b0, 6'd0, 1'b1, 16'd5, 1'b1, 16'd5, 1'b1, 1'b1, 16'd2});
        tbl.push_back('{1'b0, 6'd0, 1'b1, 16'd6, 1'b1, 16'd6, 1'b1, 1'b1, 16'd3});
        tbl.push_back('{1'b0, 6'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{1'b1, 6'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0});
        tbl.push_back('{1'b0, 6'd0, 1'b1, 16'd10, 1'b1, 16'd10, 1'b1, 1'b1, 16'd10});
        tbl.push_back('{1'b0, 6'd0, 1'b1, 16'd11, 1'b1, 16'd11, 1'b1, 1'b1, 16'd11});
        tbl.push_back('{1'b0, 6'd0, 1'b1, 16'd12, 1'b1, 16'd12, 1'b1, 1'b1, 16'd12});
        tbl.push_back('{1'b0, 6'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0});

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].ld, tbl[i].dly, tbl[i].sv, tbl[i].sd, 1'b1);
            checkOutput($sformatf("tbl%0d_m_valid", i), m_valid, tbl[i].mv);
            if (tbl[i].mv) begin
                checkOutput($sformatf("tbl%0d_m_data", i), m_data, tbl[i].md);
                checkOutput($sformatf("tbl%0d_delay_valid", i), delay_valid, tbl[i].dv);
            end
            if (tbl[i].chk_tap)
                checkOutput($sformatf("tbl%0d_m_delayed", i), m_delayed, tbl[i].mdl);
        end

        // Backpressure: one accept, then four stalled cycles, then release
        applyStimulus(1'b0, 6'd0, 1'b1, 16'd20, 1'b0);
        checkOutput("bp_first_m_data", m_data, 20);
        checkOutput("bp_s_ready_low", s_ready, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 6'd0, 1'b1, 16'd21, 1'b0);
            checkOutput($sformatf("bp_hold%0d_m_data", i), m_data, 20);
            checkOutput($sformatf("bp_hold%0d_m_valid", i), m_valid, 1);
            checkOutput($sformatf("bp_hold%0d_s_ready", i), s_ready, 0);
        end
        applyStimulus(1'b0, 6'd0, 1'b1, 16'd21, 1'b1);
        checkOutput("bp_rel_m_data", m_data, 21);
        applyStimulus(1'b0, 6'd0, 1'b1, 16'd22, 1'b1);
        checkOutput("bp_next_m_data", m_data, 22);
        applyStimulus(1'b0, 6'd0, 1'b0, 16'd0, 1'b1);
        checkOutput("bp_drain_m_valid", m_valid, 0);

        // Wrap on the DEPTH=8 instance with delay 7
        applyStimulus(1'b1, 6'd7, 1'b0, 16'd0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 6'd0, 1'b1, 16'(k), 1'b1);
            checkOutput($sformatf("wrap%0d_m_data", k), m_data8, k);
            checkOutput($sformatf("wrap%0d_delay_valid", k), delay_valid8, (k >= 7) ? 1 : 0);
            if (k >= 7)
                checkOutput($sformatf("wrap%0d_m_delayed", k), m_delayed8, k - 7);
        end

        // Maximum delay on DEPTH=64: history appears on the 64th sample
        applyStimulus(1'b1, 6'd63, 1'b0, 16'd0, 1'b1);
        for (int k = 1; k <= 70; k++) begin
            applyStimulus(1'b0, 6'd0, 1'b1, 16'(1000 + k), 1'b1);
            checkOutput($sformatf("max%0d_delay_valid", k), delay_valid, (k >= 64) ? 1 : 0);
            if (k >= 64)
                checkOutput($sformatf("max%0d_m_delayed", k), m_delayed, 1000 + k - 63);
        end

        // Reload mid-run (3 -> 5), then reset mid-stream
        applyStimulus(1'b1, 6'd3, 1'b0, 16'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 6'd0, 1'b1, 16'(300 + i), 1'b1);
            checkOutput($sformatf("rl3_%0d_delay_valid", i), delay_valid, (i >= 3) ? 1 : 0);
            if (i >= 3)
                checkOutput($sformatf("rl3_%0d_m_delayed", i), m_delayed, 300 + i - 3);
        end
        applyStimulus(1'b1, 6'd5, 1'b0, 16'd0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 6'd0, 1'b1, 16'(310 + i), 1'b1);
            checkOutput($sformatf("rl5_%0d_delay_valid", i), delay_valid, (i >= 5) ? 1 : 0);
            if (i >= 5)
                checkOutput($sformatf("rl5_%0d_m_delayed", i), m_delayed, 310 + i - 5);
        end
        reset = 1'b0;
        applyStimulus(1'b0, 6'd0, 1'b1, 16'd400, 1'b1);
        checkOutput("rst_mid_m_valid", m_valid, 0);
        checkOutput("rst_mid_delay_valid", delay_valid, 0);
        checkOutput("rst_mid_m_data", m_data, 0);
        reset = 1'b1;
        applyStimulus(1'b1, 6'd2, 1'b0, 16'd0, 1'b1);
        checkOutput("rst_idle_m_valid", m_valid, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 6'd0, 1'b1, 16'(410 + i), 1'b1);
            checkOutput($sformatf("refill%0d_m_data", i), m_data, 410 + i);
            checkOutput($sformatf("refill%0d_delay_valid", i), delay_valid, (i >= 2) ? 1 : 0);
        end
        checkOutput("refill_m_delayed", m_delayed, 410);

        s_valid = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
